// File: rtl/fila_pkg.sv
// rtl/fila_pkg.sv - shared types and constants for the Fila serializer
package fila_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    CHECK,
    START,
    DATA,
    PARITY,
    STOP
  } ser_state_t;

  localparam int unsigned FRAME_DATA_BITS = 8;
  localparam logic        LINE_IDLE       = 1'b1;
  localparam logic        START_BIT       = 1'b0;

endpackage

// File: rtl/fila_bit_timer.sv
// rtl/fila_bit_timer.sv - loadable bit-period down-counter with terminal count
module fila_bit_timer #(
  parameter int unsigned BIT_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  output logic tc_o
);

  localparam logic [7:0] RELOAD = 8'(BIT_CYCLES - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Reload at each bit entry, otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = RELOAD;
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == 8'd0);

endmodule

// File: rtl/fila_serializer.sv
// rtl/fila_serializer.sv - pops bytes from the Fila queue and sends async serial frames
module fila_serializer
  import fila_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = 4,
  parameter bit          PARITY_EN  = 1'b0
) (
  input  logic       clock_10khz,
  input  logic       reset,
  input  logic       enable_in,
  input  logic [7:0] len_in,
  input  logic [7:0] data_in,
  output logic       dequeue_out,
  output logic       serial_out,
  output logic       busy_out,
  output logic [7:0] sent_count_out
);

  localparam logic [2:0] LAST_BIT = 3'(FRAME_DATA_BITS - 1);

  ser_state_t state_q, state_d;
  logic [7:0] shreg_q, shreg_d;
  logic       parity_q, parity_d;
  logic [2:0] bit_q, bit_d;
  logic       serial_q, serial_d;
  logic [7:0] len_snap_q, len_snap_d;
  logic [7:0] sent_q, sent_d;
  logic       tmr_load;
  logic       tmr_tc;

  fila_bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_bit_timer (
    .clk_i  (clock_10khz),
    .rst_ni (reset),
    .load_i (tmr_load),
    .tc_o   (tmr_tc)
  );

  // State register.
  always_ff @(posedge clock_10khz or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus datapath updates; the line value is computed one cycle
  // ahead so serial_out comes straight from a flop.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    parity_d   = parity_q;
    bit_d      = bit_q;
    serial_d   = serial_q;
    len_snap_d = len_snap_q;
    sent_d     = sent_q;
    tmr_load   = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_in && (len_in != 8'd0)) state_d = REQ;
      end
      REQ: begin
        len_snap_d = len_in;
        state_d    = CHECK;
      end
      CHECK: begin
        // A length that did not drop by one means the queue served an
        // enqueue instead of our pop; go back and ask again.
        if (len_in == (len_snap_q - 8'd1)) begin
          shreg_d  = data_in;
          parity_d = ^data_in;
          serial_d = START_BIT;
          tmr_load = 1'b1;
          state_d  = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (tmr_tc) begin
          serial_d = shreg_q[0];
          shreg_d  = shreg_q >> 1;
          bit_d    = 3'd0;
          tmr_load = 1'b1;
          state_d  = DATA;
        end
      end
      DATA: begin
        if (tmr_tc) begin
          tmr_load = 1'b1;
          if (bit_q == LAST_BIT) begin
            if (PARITY_EN) begin
              serial_d = parity_q;
              state_d  = PARITY;
            end else begin
              serial_d = LINE_IDLE;
              state_d  = STOP;
            end
          end else begin
            bit_d    = bit_q + 3'd1;
            serial_d = shreg_q[0];
            shreg_d  = shreg_q >> 1;
          end
        end
      end
      PARITY: begin
        if (tmr_tc) begin
          serial_d = LINE_IDLE;
          tmr_load = 1'b1;
          state_d  = STOP;
        end
      end
      STOP: begin
        if (tmr_tc) begin
          sent_d  = sent_q + 8'd1;
          state_d = IDLE;
        end
      end
      default: begin
        serial_d = LINE_IDLE;
        state_d  = IDLE;
      end
    endcase
  end

  // Datapath registers; reset drops the line high at once, abandoning any frame.
  always_ff @(posedge clock_10khz or negedge reset) begin
    if (!reset) begin
      shreg_q    <= 8'd0;
      parity_q   <= 1'b0;
      bit_q      <= 3'd0;
      serial_q   <= LINE_IDLE;
      len_snap_q <= 8'd0;
      sent_q     <= 8'd0;
    end else begin
      shreg_q    <= shreg_d;
      parity_q   <= parity_d;
      bit_q      <= bit_d;
      serial_q   <= serial_d;
      len_snap_q <= len_snap_d;
      sent_q     <= sent_d;
    end
  end

  assign dequeue_out    = (state_q == REQ);
  assign busy_out       = (state_q != IDLE);
  assign serial_out     = serial_q;
  assign sent_count_out = sent_q;

endmodule

// File: tb/tb_fila_serializer.sv
// tb/tb_fila_serializer.sv - directed self-checking bench for fila_serializer
module tb_fila_serializer;

  logic       clk;
  logic       rst;
  logic       en   [2];
  logic [7:0] len  [2];
  logic [7:0] dat  [2];
  logic       deq  [2];
  logic       ser  [2];
  logic       busy [2];
  logic [7:0] cnt  [2];

  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  logic       coll    [2];
  int         deq_cnt [2];
  int         checks;
  int         errors;

  // Instance 0: 4 cycles per bit, no parity.
  fila_serializer #(.BIT_CYCLES(4), .PARITY_EN(1'b0)) dut0 (
    .clock_10khz    (clk),
    .reset          (rst),
    .enable_in      (en[0]),
    .len_in         (len[0]),
    .data_in        (dat[0]),
    .dequeue_out    (deq[0]),
    .serial_out     (ser[0]),
    .busy_out       (busy[0]),
    .sent_count_out (cnt[0])
  );

  // Instance 1: 3 cycles per bit, even parity.
  fila_serializer #(.BIT_CYCLES(3), .PARITY_EN(1'b1)) dut1 (
    .clock_10khz    (clk),
    .reset          (rst),
    .enable_in      (en[1]),
    .len_in         (len[1]),
    .data_in        (dat[1]),
    .dequeue_out    (deq[1]),
    .serial_out     (ser[1]),
    .busy_out       (busy[1]),
    .sent_count_out (cnt[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; the queue models answer a pop seen in the cycle just ended.
  task automatic tick();
    logic d0, d1;
    d0 = deq[0];
    d1 = deq[1];
    @(posedge clk);
    #1;
    if (d0 === 1'b1) begin
      deq_cnt[0]++;
      if (coll[0]) begin
        coll[0] = 1'b0;
        q0.push_back(8'h99);
      end else if (q0.size() > 0) begin
        dat[0] = q0.pop_front();
      end
      len[0] = 8'(q0.size());
    end
    if (d1 === 1'b1) begin
      deq_cnt[1]++;
      if (q1.size() > 0) dat[1] = q1.pop_front();
      len[1] = 8'(q1.size());
    end
  endtask

  // Waits for a start bit, then checks every cycle of the frame and that the
  // block is idle with the line high exactly nb*bc cycles after START entry.
  task automatic wait_frame(input int w, input string tag, input logic [10:0] exp,
                            input int nb, input int bc);
    int t;
    logic [10:0] obs;
    logic cons;
    logic s;
    t = 0;
    while (ser[w] !== 1'b0 && t < 300) begin
      tick();
      t++;
    end
    check({tag, " start"}, 32'(t < 300), 32'd1);
    obs  = '0;
    cons = 1'b1;
    for (int i = 0; i < nb; i++) begin
      for (int j = 0; j < bc; j++) begin
        s = ser[w];
        if (j == 0) obs[i] = s;
        else if (s !== obs[i]) cons = 1'b0;
        tick();
      end
    end
    check({tag, " bits"}, 32'(obs), 32'(exp));
    check({tag, " steady"}, 32'(cons), 32'd1);
    check({tag, " idle_end"}, {30'd0, busy[w], ser[w]}, 32'd1);
  endtask

  initial begin
    int t;
    logic [7:0] drain [8];
    checks = 0;
    errors = 0;
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      en[k] = 1'b0; len[k] = 8'd0; dat[k] = 8'd0; coll[k] = 1'b0; deq_cnt[k] = 0;
    end

    // Reset held for 3 cycles, then idle with an empty queue.
    repeat (3) tick();
    check("rst serial0", 32'(ser[0]), 32'd1);
    check("rst busy0", 32'(busy[0]), 32'd0);
    check("rst cnt0", 32'(cnt[0]), 32'd0);
    check("rst deq0", 32'(deq[0]), 32'd0);
    check("rst serial1", 32'(ser[1]), 32'd1);
    rst = 1'b1;
    en[0] = 1'b1;
    en[1] = 1'b1;
    repeat (12) begin
      tick();
      if (ser[0] !== 1'b1 || busy[0] !== 1'b0) t = -1;
    end
    check("empty deq pulses", 32'(deq_cnt[0] + deq_cnt[1]), 32'd0);
    check("empty busy", {30'd0, busy[0], busy[1]}, 32'd0);
    check("empty line", {30'd0, ser[0], ser[1]}, 32'd3);

    // Single byte 0xA5: line 0,1,0,1,0,0,1,0,1,1.
    q0.push_back(8'hA5);
    len[0] = 8'd1;
    wait_frame(0, "a5", 11'h34A, 10, 4);
    check("a5 deq", 32'(deq_cnt[0]), 32'd1);
    check("a5 cnt", 32'(cnt[0]), 32'd1);
    check("a5 len", 32'(len[0]), 32'd0);

    // Parity instance: 0x03 (parity 0) then 0x07 (parity 1), back to back.
    q1.push_back(8'h03);
    q1.push_back(8'h07);
    len[1] = 8'd2;
    wait_frame(1, "par03", 11'h406, 11, 3);
    wait_frame(1, "par07", 11'h60E, 11, 3);
    check("par cnt", 32'(cnt[1]), 32'd2);
    check("par deq", 32'(deq_cnt[1]), 32'd2);

    // Enqueue collision: first pop ignored (len 2->3), retry pops 0x3C.
    q0.push_back(8'h3C);
    q0.push_back(8'h5A);
    coll[0] = 1'b1;
    len[0] = 8'd2;
    wait_frame(0, "coll3c", 11'h278, 10, 4);
    check("coll deq", 32'(deq_cnt[0]), 32'd3);
    check("coll cnt", 32'(cnt[0]), 32'd2);
    wait_frame(0, "coll5a", 11'h2B4, 10, 4);
    wait_frame(0, "coll99", 11'h332, 10, 4);
    check("coll cnt end", 32'(cnt[0]), 32'd4);

    // Reset during data bit 3 of 0x55 (bit value 0).
    q0.push_back(8'h55);
    len[0] = 8'd1;
    t = 0;
    while (ser[0] !== 1'b0 && t < 300) begin
      tick();
      t++;
    end
    check("mid start", 32'(t < 300), 32'd1);
    repeat (17) tick();
    check("mid bit3", {30'd0, busy[0], ser[0]}, 32'd2);
    rst = 1'b0;
    #1;
    check("mid async line", 32'(ser[0]), 32'd1);
    check("mid async busy", 32'(busy[0]), 32'd0);
    check("mid async cnt", 32'(cnt[0]), 32'd0);
    repeat (2) tick();
    q0.push_back(8'hC3);
    len[0] = 8'd1;
    rst = 1'b1;
    wait_frame(0, "afterrst", 11'h386, 10, 4);
    check("afterrst cnt", 32'(cnt[0]), 32'd1);

    // Bring the count to 250 with 249 more frames.
    for (int i = 0; i < 249; i++) q0.push_back(8'(i));
    len[0] = 8'(q0.size());
    t = 0;
    while (cnt[0] !== 8'd250 && t < 20000) begin
      tick();
      t++;
    end
    check("preset cnt", 32'(cnt[0]), 32'd250);
    tick();
    check("preset idle", {30'd0, busy[0], ser[0]}, 32'd1);
    check("preset len", 32'(len[0]), 32'd0);

    // Drain 8 bytes in order; the count wraps 255 -> 0 -> 2.
    drain = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h11, 8'hEE, 8'h5A, 8'hA5};
    for (int i = 0; i < 8; i++) q0.push_back(drain[i]);
    len[0] = 8'd8;
    for (int i = 0; i < 8; i++) begin
      wait_frame(0, $sformatf("drain%0d", i), {2'b01, drain[i], 1'b0}, 10, 4);
      if (i == 5) check("wrap zero", 32'(cnt[0]), 32'd0);
    end
    check("drain cnt", 32'(cnt[0]), 32'd2);
    check("drain len", 32'(len[0]), 32'd0);
    t = deq_cnt[0];
    repeat (20) tick();
    check("drain no req", 32'(deq_cnt[0] - t), 32'd0);
    check("drain idle", {30'd0, busy[0], ser[0]}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fila_serializer.md
Name: fila_serializer

Overview:
- Drain side of the Fila byte queue: pops bytes through the queue's dequeue/data_out/len_out interface and transmits each one as an asynchronous serial frame.
- Counterpart to the deserializer that fills the queue.
- Runs in the queue's clock domain: clock_10khz.
- Frame: start bit (0), 8 data bits LSB first, optional even parity bit, stop bit (1).

Parameters:
- BIT_CYCLES, 4: clock cycles per serial bit; legal range 1..255.
- PARITY_EN, 0: 1 inserts an even-parity bit between data bit 7 and the stop bit.

Ports:
- clock_10khz  input  1  sole clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- enable_in  input  1  1 permits new frames to start; sampled only in IDLE.
- len_in  input  8  element count from queue len_out.
- data_in  input  8  byte from queue data_out.
- dequeue_out  output  1  one-cycle pop request to queue dequeue_in.
- serial_out  output  1  serial line; idles high.
- busy_out  output  1  1 in any state other than IDLE.
- sent_count_out  output  8  frames completed; wraps 255 -> 0.

Behaviour:
- Reset (reset=0, async): state IDLE, serial_out=1, dequeue_out=0, busy_out=0, sent_count_out=0, shift register and counters cleared.
- Reset mid-frame: the frame is abandoned and serial_out returns to 1 immediately. Any byte already popped from the queue is lost.
- States: IDLE, REQ, CHECK, START, DATA, PARITY, STOP.
- IDLE:
  - If enable_in=1 and len_in!=0: go to REQ.
  - Else stay in IDLE.
- REQ (exactly 1 cycle):
  - dequeue_out=1, decoded from state (Moore output); it is 0 in every other state.
  - len_snap <= len_in.
  - Next state CHECK.
- CHECK (1 cycle; data_in and len_in now reflect the queue's response):
  - If len_in == len_snap-1 (8-bit), the pop was accepted: shreg <= data_in, parity <= ^data_in, go to START.
  - Else a simultaneous enqueue took priority in the queue and the pop was ignored: go to IDLE and retry. No frame is sent and sent_count_out is unchanged.
- Back-to-back requests are therefore separated by at least 2 cycles, which keeps the queue's FSM back in its idle state before the next request.
- START: serial_out=0 for BIT_CYCLES cycles.
- DATA: serial_out=shreg[0] for BIT_CYCLES cycles per bit, shreg shifts right, bit counter counts 0..7. Then go to PARITY if PARITY_EN=1, else STOP.
- PARITY: serial_out=parity for BIT_CYCLES cycles.
- STOP:
  - serial_out=1 for BIT_CYCLES cycles.
  - On exit, sent_count_out increments (wraps) and state goes to IDLE.
  - IDLE may start the next request on the following cycle, so consecutive frames are separated by at least 1 idle-high cycle.
- Bit timer: 8-bit down-counter loaded with BIT_CYCLES-1 on each bit entry; the bit ends when it reaches 0.
- serial_out is driven from a register: glitch-free, changes only on clock edges.
- Frame length: (10+PARITY_EN)*BIT_CYCLES cycles from START entry to IDLE.
- enable_in=0 mid-frame: the current frame completes; no new REQ is issued.
- Empty queue (len_in=0): stay in IDLE, serial_out=1, dequeue_out never asserted.
- Out-of-domain inputs are not handled here; all inputs are synchronous to clock_10khz.

Decomposition:
- Shared package fila_pkg:
  - state enum ser_state_t (IDLE, REQ, CHECK, START, DATA, PARITY, STOP).
  - FRAME_DATA_BITS = 8, LINE_IDLE = 1'b1, START_BIT = 1'b0.
- One sub-module, fila_bit_timer: loadable down-counter with a terminal-count pulse, parameterised by BIT_CYCLES.
- FSM, shift register and counters stay in fila_serializer.

Test Plan:
- Reset/idle: hold reset=0 for 3 cycles, release with len_in=0 -> serial_out=1, dequeue_out never 1, busy_out=0, sent_count_out=0.
- Single byte, BIT_CYCLES=4, PARITY_EN=0: queue model holds 0xA5 -> exactly one dequeue_out pulse; line shows 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; sent_count_out=1; 40 cycles from START entry to IDLE.
- Parity: PARITY_EN=1, bytes 0x03 then 0x07 -> parity bits 0 then 1; frames of 11 bits; sent_count_out=2; gap between frames of at least 1 high cycle.
- Enqueue collision: queue model ignores the pop and reports len 2->3 in CHECK -> no frame started, retry REQ; second pop succeeds (len 3->2) and exactly one frame of the correct byte is sent.
- Reset mid-frame: assert reset=0 during DATA bit 3 -> serial_out=1 immediately (async), busy_out=0, sent_count_out=0; after release with len_in=1 a new complete frame is sent.
- Drain and wrap: enable_in=1, queue preloaded with 8 bytes, sent_count_out preset by running 250 frames -> 8 frames sent in order, len reaches 0 and the block stays IDLE; sent_count_out wraps 255 -> 0 -> 2.
